// File: rtl/gmii_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// gmii_tx_framer_pkg
//   Shared Ethernet framing constants, FSM state encoding and the octet-wide
//   reflected CRC32 step used by the Tx framer (and reusable by Rx checks).
//   No ports; import with `import gmii_tx_framer_pkg::*;`.
// -----------------------------------------------------------------------------
package gmii_tx_framer_pkg;

    localparam int unsigned ETH_PREAMBLE_LEN = 7;
    localparam logic [7:0]  ETH_PRE_OCTET    = 8'h55;
    localparam logic [7:0]  ETH_SFD          = 8'hD5;
    localparam int unsigned ETH_MIN_FRAME    = 60;
    localparam int unsigned ETH_MAX_FRAME    = 1514;
    localparam int unsigned ETH_FCS_LEN      = 4;
    localparam logic [31:0] ETH_CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC_INIT     = 32'hFFFF_FFFF;

    // One-hot framer states.
    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_PRE  = 6'b000010,
        ST_DATA = 6'b000100,
        ST_PAD  = 6'b001000,
        ST_FCS  = 6'b010000,
        ST_GAP  = 6'b100000
    } state_t;

    // One octet of the reflected (LSB-first) CRC32; no final inversion.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  d);
        logic [31:0] poly_r;
        logic [31:0] c;
        for (int i = 0; i < 32; i++) poly_r[i] = ETH_CRC_POLY[31-i];
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_gen.sv
// -----------------------------------------------------------------------------
// eth_crc32_gen
//   Octet-wide reflected CRC32 register (init FFFFFFFF, no output inversion).
//   Ports:
//     clk    in   clock
//     rst    in   asynchronous active-high reset (register -> init value)
//     clear  in   synchronous reload of the init value
//     gate   in   fold d_in into the CRC this cycle
//     d_in   in   8-bit data octet
//     crc    out  32-bit running CRC register
// -----------------------------------------------------------------------------
module eth_crc32_gen
    import gmii_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        gate,
    input  logic [7:0]  d_in,
    output logic [31:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        crc <= ETH_CRC_INIT;
        else if (clear) crc <= ETH_CRC_INIT;
        else if (gate)  crc <= crc32_next(crc, d_in);
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// -----------------------------------------------------------------------------
// gmii_tx_framer
//   Transmit framer: preamble + SFD, frame octets read from the Tx packet
//   buffer, optional zero pad to 60 octets, CRC32 FCS, then inter-frame gap.
//   Optional feature macro: GMII_TX_FRAMER_PAD_EN (zero-pad short frames).
//   Ports:
//     clk        in   Tx clock, one octet per cycle
//     rst        in   asynchronous active-high reset
//     tx_req     in   frame ready in buffer; tx_len valid while high
//     tx_len     in   frame length in octets, excluding FCS
//     tx_ack     out  pulse: request accepted or rejected
//     tx_err     out  pulse with tx_ack for a zero or oversized length
//     rd_a       out  buffer read address (RAM has one cycle latency)
//     rd_d       in   buffer read data for the previous rd_a
//     eth_out    out  GMII TXD (registered)
//     eth_out_s  out  GMII TX_EN (registered)
//     busy       out  high from an accepting tx_ack through the end of the gap
// -----------------------------------------------------------------------------
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int unsigned IFG     = 12,
    parameter int unsigned MAX_LEN = ETH_MAX_FRAME
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req,
    input  logic [10:0] tx_len,
    output logic        tx_ack,
    output logic        tx_err,
    output logic [10:0] rd_a,
    input  logic [7:0]  rd_d,
    output logic [7:0]  eth_out,
    output logic        eth_out_s,
    output logic        busy
);

    localparam logic [10:0] SFD_IDX   = 11'(ETH_PREAMBLE_LEN);
    localparam logic [10:0] FCS_LAST  = 11'(ETH_FCS_LEN - 1);
    // The accepting IDLE cycle is the last idle octet of the gap, so GAP
    // itself lasts IFG-1 cycles and back-to-back frames are spaced by IFG.
    localparam logic [10:0] GAP_LAST  = 11'(IFG - 2);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
`ifdef GMII_TX_FRAMER_PAD_EN
    localparam logic [10:0] MIN_LEN   = 11'(ETH_MIN_FRAME);
`endif

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic [10:0] len_q;
    logic        len_bad, accept;
    logic [7:0]  octet;
    logic        octet_v;
    logic        crc_clear, crc_gate;
    logic [31:0] crc, fcs;

    assign len_bad = (tx_len == '0) || (tx_len > MAX_LEN_W);
    assign accept  = (state == ST_IDLE) && tx_req && !len_bad;
    assign fcs     = ~crc;

    eth_crc32_gen u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (crc_clear),
        .gate  (crc_gate),
        .d_in  (octet),
        .crc   (crc)
    );

    // State register. Reset lands in IDLE with no gap pending, so the first
    // request after reset is taken at once; TX_EN drops with rst itself.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            len_q     <= '0;
            rd_a      <= '0;
            eth_out   <= '0;
            eth_out_s <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (accept) len_q <= tx_len;
            // rd_a=0 is presented during the SFD cycle, so data octet 0
            // arrives on rd_d in the first DATA cycle.
            if (state == ST_IDLE)
                rd_a <= '0;
            else if ((state == ST_PRE && cnt == SFD_IDX) || state == ST_DATA)
                rd_a <= rd_a + 11'd1;
            eth_out   <= octet;
            eth_out_s <= octet_v;
        end
    end

    // Next-state and per-state octet counter.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 11'd1;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = ST_PRE;
            end
            ST_PRE: if (cnt == SFD_IDX) begin
                state_nxt = ST_DATA;
                cnt_nxt   = '0;
            end
            ST_DATA: if (cnt == len_q - 11'd1) begin
`ifdef GMII_TX_FRAMER_PAD_EN
                if (len_q < MIN_LEN) begin
                    state_nxt = ST_PAD;          // cnt keeps counting octets sent
                end else begin
                    state_nxt = ST_FCS;
                    cnt_nxt   = '0;
                end
`else
                state_nxt = ST_FCS;
                cnt_nxt   = '0;
`endif
            end
`ifdef GMII_TX_FRAMER_PAD_EN
            ST_PAD: if (cnt == MIN_LEN - 11'd1) begin
                state_nxt = ST_FCS;
                cnt_nxt   = '0;
            end
`endif
            ST_FCS: if (cnt == FCS_LAST) begin
                state_nxt = ST_GAP;
                cnt_nxt   = '0;
            end
            ST_GAP: if (cnt == GAP_LAST) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: octet to be registered onto GMII, CRC control, handshake.
    always_comb begin
        octet     = '0;
        octet_v   = 1'b0;
        crc_gate  = 1'b0;
        crc_clear = 1'b0;
        tx_ack    = 1'b0;
        tx_err    = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                crc_clear = 1'b1;
                tx_ack    = tx_req;
                tx_err    = tx_req && len_bad;
                busy      = accept;
            end
            ST_PRE: begin
                octet_v = 1'b1;
                octet   = (cnt == SFD_IDX) ? ETH_SFD : ETH_PRE_OCTET;
            end
            ST_DATA: begin
                octet_v  = 1'b1;
                octet    = rd_d;
                crc_gate = 1'b1;
            end
`ifdef GMII_TX_FRAMER_PAD_EN
            ST_PAD: begin
                octet_v  = 1'b1;
                crc_gate = 1'b1;
            end
`endif
            ST_FCS: begin
                octet_v = 1'b1;
                case (cnt[1:0])              // low octet of the FCS first
                    2'd0:    octet = fcs[7:0];
                    2'd1:    octet = fcs[15:8];
                    2'd2:    octet = fcs[23:16];
                    default: octet = fcs[31:24];
                endcase
            end
            ST_GAP: ;
            default: busy = 1'b0;
        endcase
    end

endmodule
